// File: rtl/mapa_leitor.sv
// mapa_leitor: read-side responder for the snake game map memory.
//
// Answers "what is at (x,y)?" for two requesters, the snake head logic
// (cobra) and the fruit spawner (fruta). One query is outstanding at a time.
// If both requesters ask in the same cycle, round-robin arbitration picks one.
// An in-bounds cell is read from the map RAM through its synchronous read
// port. An out-of-bounds cell is answered as PAREDE and the RAM is not touched.
//
// Ports:
//   clk, reset                   system clock, asynchronous active-high reset
//   cobra_req/x/y                cobra query (level request, held until ack)
//   cobra_ack, cobra_conteudo    one-cycle ack, plus the cell content that goes with it
//   fruta_req/x/y                fruta query (same rules as cobra)
//   fruta_ack, fruta_conteudo    one-cycle ack, plus the cell content that goes with it
//   mem_rd_en, mem_addr          registered map RAM read request
//   mem_dado                     map RAM read data, MEM_LAT cycles after the request
//
// Content encoding: 0 NADA, 1 COBRA, 2 FRUTA, 3 PAREDE.

module mapa_leitor #(
  parameter int LARGURA = 80,
  parameter int ALTURA  = 60,
  parameter int ADDR_W  = 13,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cobra_req,
  input  logic [9:0]        cobra_x,
  input  logic [9:0]        cobra_y,
  output logic              cobra_ack,
  output logic [1:0]        cobra_conteudo,
  input  logic              fruta_req,
  input  logic [9:0]        fruta_x,
  input  logic [9:0]        fruta_y,
  output logic              fruta_ack,
  output logic [1:0]        fruta_conteudo,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_dado
);

  localparam logic [1:0] PAREDE = 2'd3;
  localparam int         CNT_W  = $clog2(MEM_LAT + 1) + 1;

  typedef enum logic [1:0] {OCIOSO, ENDERECO, ESPERA, RESPONDE} estado_t;

  estado_t          estado, prox_estado;
  logic [9:0]       x_q, y_q;
  logic             id_q;         // 0 = cobra, 1 = fruta
  logic             ultimo_id;    // requester served most recently
  logic [CNT_W-1:0] cnt;
  logic             conceder_fruta;
  logic             fora_limite;
  logic             fim_espera;
  logic [19:0]      addr_full;

  // If only one requester is asking, it wins. If both are asking, the one
  // that was not served last wins.
  assign conceder_fruta = fruta_req && (!cobra_req || !ultimo_id);

  assign fora_limite = ({22'd0, x_q} >= 32'(LARGURA)) ||
                       ({22'd0, y_q} >= 32'(ALTURA));

  // Compute the product at the full coordinate width first, then truncate
  // it to the RAM address width.
  assign addr_full = 20'(y_q) * 20'(LARGURA) + 20'(x_q);

  assign fim_espera = (cnt == CNT_W'(MEM_LAT));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  // Next-state logic. Each query runs one pass: grant, address, optional
  // wait for the RAM, and a single response cycle.
  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:   if (cobra_req || fruta_req) prox_estado = ENDERECO;
      ENDERECO: prox_estado = fora_limite ? RESPONDE : ESPERA;
      ESPERA:   if (fim_espera) prox_estado = RESPONDE;
      RESPONDE: prox_estado = OCIOSO;
      default:  prox_estado = OCIOSO;
    endcase
  end

  // Datapath and registered outputs.
  // The ack and content registers are loaded on the edge that enters
  // RESPONDE, so both are visible during that state. The ack is cleared on
  // the edge that leaves RESPONDE. The content registers are not cleared
  // then; they keep their value until the next response to that requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      id_q           <= 1'b0;
      ultimo_id      <= 1'b1;
      cnt            <= '0;
      mem_rd_en      <= 1'b0;
      mem_addr       <= '0;
      cobra_ack      <= 1'b0;
      cobra_conteudo <= '0;
      fruta_ack      <= 1'b0;
      fruta_conteudo <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (conceder_fruta) begin
            x_q  <= fruta_x;
            y_q  <= fruta_y;
            id_q <= 1'b1;
          end else if (cobra_req) begin
            x_q  <= cobra_x;
            y_q  <= cobra_y;
            id_q <= 1'b0;
          end
        end
        ENDERECO: begin
          cnt <= '0;
          if (fora_limite) begin
            if (id_q) begin
              fruta_ack      <= 1'b1;
              fruta_conteudo <= PAREDE;
            end else begin
              cobra_ack      <= 1'b1;
              cobra_conteudo <= PAREDE;
            end
          end else begin
            mem_addr  <= ADDR_W'(addr_full);
            mem_rd_en <= 1'b1;
          end
        end
        ESPERA: begin
          if (fim_espera) begin
            if (id_q) begin
              fruta_ack      <= 1'b1;
              fruta_conteudo <= mem_dado;
            end else begin
              cobra_ack      <= 1'b1;
              cobra_conteudo <= mem_dado;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPONDE: begin
          cobra_ack <= 1'b0;
          fruta_ack <= 1'b0;
          ultimo_id <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule
